// File: rtl/vga_sync_gen.sv
// 640x480 VGA raster timing: beam counters, sync pins, active-area flag and tile coordinates.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN.
module vga_sync_gen #(
    parameter int unsigned H_TOTAL = 800,
    parameter int unsigned H_SYNC  = 96,
    parameter int unsigned H_LEFT  = 144,
    parameter int unsigned V_TOTAL = 521,
    parameter int unsigned V_SYNC  = 2,
    parameter int unsigned V_TOP   = 31
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       bright,
    output logic [6:0] tile_col,
    output logic [5:0] tile_row,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned CW     = 10;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 6;
    localparam int unsigned FC_W   = 8;
    localparam int unsigned ACT_W  = 640;
    localparam int unsigned ACT_H  = 480;

    logic [CW-1:0]    hcount_q, hcount_d;
    logic [CW-1:0]    vcount_q, vcount_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             bright_q, bright_d;
    logic [COL_W-1:0] tile_col_q, tile_col_d;
    logic [ROW_W-1:0] tile_row_q, tile_row_d;
    logic             frame_start_q, frame_start_d;
    logic             h_wrap, v_wrap;
    logic             h_act, v_act;
    logic [CW-1:0]    h_off, v_off;

    // Counter advance; decode is taken from the next-state values so flags line up with coordinates.
    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_start_d = 1'b0;
        h_wrap        = (hcount_q == CW'(H_TOTAL - 1));
        v_wrap        = (vcount_q == CW'(V_TOTAL - 1));
        if (pix_en) begin
            if (h_wrap) begin
                hcount_d = '0;
                if (v_wrap) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vcount_d = vcount_q + CW'(1);
                end
            end else begin
                hcount_d = hcount_q + CW'(1);
            end
        end

        hsync_d    = (hcount_d >= CW'(H_SYNC));
        vsync_d    = (vcount_d >= CW'(V_SYNC));
        h_act      = (hcount_d > CW'(H_LEFT)) && (hcount_d <= CW'(H_LEFT + ACT_W));
        v_act      = (vcount_d > CW'(V_TOP))  && (vcount_d <= CW'(V_TOP + ACT_H));
        bright_d   = h_act && v_act;
        h_off      = hcount_d - CW'(H_LEFT + 1);
        v_off      = vcount_d - CW'(V_TOP + 1);
        tile_col_d = bright_d ? COL_W'(h_off >> 3) : '0;
        tile_row_d = bright_d ? ROW_W'(v_off >> 3) : '0;
    end

    always_ff @(posedge clk1) begin
        if (!rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            bright_q      <= 1'b0;
            tile_col_q    <= '0;
            tile_row_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            bright_q      <= bright_d;
            tile_col_q    <= tile_col_d;
            tile_row_q    <= tile_row_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign bright      = bright_q;
    assign tile_col    = tile_col_q;
    assign tile_row    = tile_row_q;
    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;

    // Counts on the same edge that raises frame_start.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + FC_W'(1);
        end
    end

    always_ff @(posedge clk1) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: directed vector table on a default-timing instance plus
// frame-level sequences on a small-timing instance so whole frames fit in a short run.
module tb_vga_sync_gen;

    logic       clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Default-timing instance
    logic       rst_a, en_a;
    logic [9:0] hc_a, vc_a;
    logic       hs_a, vs_a, br_a, fs_a;
    logic [6:0] tc_a;
    logic [5:0] tr_a;
    logic [7:0] fc_a;

    vga_sync_gen dut_a (
        .clk1(clk1), .rst(rst_a), .pix_en(en_a),
        .hcount(hc_a), .vcount(vc_a), .hsync(hs_a), .vsync(vs_a), .bright(br_a),
        .tile_col(tc_a), .tile_row(tr_a), .frame_start(fs_a), .frame_cnt(fc_a)
    );

    // Small-timing instance: 10 clocks/line, 4 lines/frame
    logic       rst_b, en_b;
    logic [9:0] hc_b, vc_b;
    logic       hs_b, vs_b, br_b, fs_b;
    logic [6:0] tc_b;
    logic [5:0] tr_b;
    logic [7:0] fc_b;

    vga_sync_gen #(
        .H_TOTAL(10), .H_SYNC(3), .H_LEFT(2), .V_TOTAL(4), .V_SYNC(2), .V_TOP(1)
    ) dut_b (
        .clk1(clk1), .rst(rst_b), .pix_en(en_b),
        .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b), .bright(br_b),
        .tile_col(tc_b), .tile_row(tr_b), .frame_start(fs_b), .frame_cnt(fc_b)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       en;
        int         n;
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       br;
        logic [6:0] tc;
        logic [5:0] tr;
        logic       fs;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic step(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    logic [44:0] got_a, exp_a;
    logic [43:0] got_b, exp_b;
    int          mh, mv, mfc, last_fs, pulses, cyc;
    logic        mfs, mbr;
    logic [6:0]  mtc;
    logic [5:0]  mtr;

    initial begin
        //            rst  en   n      h    v   hs  vs  br  tc  tr  fs
        vecs[0]  = '{1'b0, 1'b1, 1,     0,   0, 0, 0, 0,  0, 0, 0};
        vecs[1]  = '{1'b1, 1'b1, 1,     1,   0, 0, 0, 0,  0, 0, 0};
        vecs[2]  = '{1'b1, 1'b1, 1,     2,   0, 0, 0, 0,  0, 0, 0};
        vecs[3]  = '{1'b1, 1'b1, 1,     3,   0, 0, 0, 0,  0, 0, 0};
        vecs[4]  = '{1'b1, 1'b1, 1,     4,   0, 0, 0, 0,  0, 0, 0};
        vecs[5]  = '{1'b1, 1'b1, 1,     5,   0, 0, 0, 0,  0, 0, 0};
        vecs[6]  = '{1'b1, 1'b1, 90,    95,  0, 0, 0, 0,  0, 0, 0};
        vecs[7]  = '{1'b1, 1'b1, 1,     96,  0, 1, 0, 0,  0, 0, 0};
        vecs[8]  = '{1'b1, 1'b1, 703,   799, 0, 1, 0, 0,  0, 0, 0};
        vecs[9]  = '{1'b1, 1'b1, 1,     0,   1, 0, 0, 0,  0, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 3,     0,   1, 0, 0, 0,  0, 0, 0};
        vecs[11] = '{1'b1, 1'b1, 24944, 144, 32, 1, 1, 0, 0, 0, 0};
        vecs[12] = '{1'b1, 1'b1, 1,     145, 32, 1, 1, 1, 0, 0, 0};
        vecs[13] = '{1'b1, 1'b1, 8,     153, 32, 1, 1, 1, 1, 0, 0};
        vecs[14] = '{1'b1, 1'b1, 631,   784, 32, 1, 1, 1, 79, 0, 0};
        vecs[15] = '{1'b1, 1'b1, 1,     785, 32, 1, 1, 0, 0, 0, 0};
        vecs[16] = '{1'b1, 1'b1, 5765,  150, 40, 1, 1, 1, 0, 1, 0};
        vecs[17] = '{1'b0, 1'b1, 1,     0,   0, 0, 0, 0,  0, 0, 0};
        vecs[18] = '{1'b1, 1'b1, 1,     1,   0, 0, 0, 0,  0, 0, 0};

        rst_a = 1'b0; en_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b0;
        step(1);

        for (int i = 0; i < NV; i++) begin
            rst_a = vecs[i].rst;
            en_a  = vecs[i].en;
            step(vecs[i].n);
            got_a = {hc_a, vc_a, hs_a, vs_a, br_a, tc_a, tr_a, fs_a, fc_a};
            exp_a = {vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs, vecs[i].br,
                     vecs[i].tc, vecs[i].tr, vecs[i].fs, 8'd0};
            check($sformatf("vec%0d", i), 64'(got_a), 64'(exp_a));
        end

        // pix_en pattern 1,0,0,1 starting from hcount=1
        en_a = 1'b1; step(1); check("toggle_e1", 64'(hc_a), 64'd2);
        en_a = 1'b0; step(1); check("toggle_d1", 64'(hc_a), 64'd2);
        en_a = 1'b0; step(1); check("toggle_d2", 64'(hc_a), 64'd2);
        en_a = 1'b1; step(1); check("toggle_e2", 64'(hc_a), 64'd3);
        en_a = 1'b0;

        // Small instance: 258 frames against a behavioural model, every cycle
        rst_b = 1'b0; step(1);
        check("b_reset", 64'({hc_b, vc_b, hs_b, vs_b, br_b, fs_b, fc_b}), 64'd0);
        rst_b = 1'b1; en_b = 1'b1;
        mh = 0; mv = 0; mfc = 0; last_fs = -1; pulses = 0;
        for (cyc = 1; cyc <= 258 * 40; cyc++) begin
            mfs = (mh == 9) && (mv == 3);
            if (mh == 9) begin
                mh = 0;
                mv = (mv == 3) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
`ifdef VGA_FRAME_CNT_EN
            if (mfs) mfc = (mfc + 1) % 256;
`endif
            mbr = (mh >= 3) && (mh <= 642) && (mv >= 2) && (mv <= 481);
            mtc = mbr ? 7'((mh - 3) / 8) : 7'd0;
            mtr = mbr ? 6'((mv - 2) / 8) : 6'd0;
            step(1);
            got_b = {hc_b, vc_b, hs_b, vs_b, br_b, tc_b, tr_b, fs_b, fc_b};
            exp_b = {10'(mh), 10'(mv), 1'(mh >= 3), 1'(mv >= 2), mbr, mtc, mtr, mfs, 8'(mfc)};
            check($sformatf("b_cyc%0d", cyc), 64'(got_b), 64'(exp_b));
            if (fs_b) begin
                pulses++;
                if (last_fs >= 0) check($sformatf("b_period%0d", pulses), 64'(cyc - last_fs), 64'd40);
                last_fs = cyc;
            end
        end
        check("b_pulses", 64'(pulses), 64'd258);

        // Hold at (0,0) with pix_en low: frame_start for one clock only
        step(39);
        check("b_pre_wrap", 64'({hc_b, vc_b}), 64'({10'd9, 10'd3}));
        step(1);
        check("b_wrap_fs", 64'({hc_b, vc_b, fs_b}), 64'({10'd0, 10'd0, 1'b1}));
        en_b = 1'b0;
        step(1);
        check("b_hold_fs1", 64'({hc_b, vc_b, fs_b}), 64'({10'd0, 10'd0, 1'b0}));
        step(1);
        check("b_hold_fs2", 64'({hc_b, vc_b, fs_b}), 64'({10'd0, 10'd0, 1'b0}));

        // Reset mid-frame with pix_en high yields no frame_start
        en_b = 1'b1; step(25);
        rst_b = 1'b0; step(1);
        check("b_midreset", 64'({hc_b, vc_b, hs_b, vs_b, br_b, tc_b, tr_b, fs_b, fc_b}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
